// File: rtl/sc_sng_bank_if.sv
// Load/stream bundle for sc_sng_bank: value load handshake in, stochastic bitstreams out.
interface sc_sng_bank_if #(
   parameter int N = 8,
   parameter int W = 8
);
   logic           load_valid;
   logic           load_ready;
   logic [N*W-1:0] load_din;
   logic [N*W-1:0] load_weight;
   logic [W-1:0]   load_bias;
   logic           en;
   logic           abort;
   logic [N-1:0]   din;
   logic [N-1:0]   weight;
   logic           bias;
   logic           stream_valid;
   logic           done;

   modport master (
      output load_valid, load_din, load_weight, load_bias, en, abort,
      input  load_ready, din, weight, bias, stream_valid, done
   );

   modport slave (
      input  load_valid, load_din, load_weight, load_bias, en, abort,
      output load_ready, din, weight, bias, stream_valid, done
   );
endinterface

// File: rtl/sc_sng_bank.sv
// Bipolar stochastic number generator bank; first stream bit valid the cycle after load is accepted.
// Accepts loads only while idle; en=0 stalls the stream in place, abort cancels the run.
module sc_sng_bank #(
   parameter int         K      = 3,
   parameter int         N      = 2**K,
   parameter int         W      = 8,
   parameter int         LEN    = 255,
   parameter logic [7:0] SEED_A = 8'hA5,
   parameter logic [7:0] SEED_B = 8'h3C
) (
   input logic          clk,
   input logic          reset,
   sc_sng_bank_if.slave bus
);
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_RUN   = 2'd1;
   localparam logic [1:0]  ST_DONE  = 2'd2;
   localparam logic [15:0] LAST     = 16'(LEN - 1);
   localparam logic [2:0]  BIAS_ROT = 3'(N % 8);

   generate
      if (W != 8) begin : g_bad_w
         $error("sc_sng_bank: W must be 8");
      end
      if (LEN < 1 || LEN > 65535) begin : g_bad_len
         $error("sc_sng_bank: LEN must be in 1..65535");
      end
      if (SEED_A == 8'h00 || SEED_B == 8'h00) begin : g_bad_seed
         $error("sc_sng_bank: LFSR seeds must be nonzero");
      end
   endgenerate

   logic [1:0]     state;
   logic [7:0]     lfsr_a;
   logic [7:0]     lfsr_b;
   logic [15:0]    cnt;
   logic [N*W-1:0] din_q;
   logic [N*W-1:0] weight_q;
   logic [W-1:0]   bias_q;
   logic           stream_vld;
   logic [N-1:0]   din_b;
   logic [N-1:0]   weight_b;
   logic           bias_b;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Rotation keeps the word nonzero and a bijection, so each lane still sees every value 1..255 once per period.
   function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] r);
      logic [15:0] t;
      t = {x, x} << r;
      return t[15:8];
   endfunction

   assign stream_vld = (state == ST_RUN) && bus.en && !bus.abort;

   always_comb begin
      din_b    = '0;
      weight_b = '0;
      bias_b   = 1'b0;
      if (stream_vld) begin
         for (int i = 0; i < N; i++) begin
            din_b[i]    = rotl8(lfsr_a, 3'(i % 8)) <= din_q[i*W +: W];
            weight_b[i] = rotl8(lfsr_b, 3'(i % 8)) <= weight_q[i*W +: W];
         end
         bias_b = rotl8(lfsr_b, BIAS_ROT) <= bias_q;
      end
   end

   assign bus.din          = din_b;
   assign bus.weight       = weight_b;
   assign bus.bias         = bias_b;
   assign bus.stream_valid = stream_vld;
   assign bus.load_ready   = (state == ST_IDLE);
   assign bus.done         = (state == ST_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         lfsr_a   <= SEED_A;
         lfsr_b   <= SEED_B;
         cnt      <= '0;
         din_q    <= '0;
         weight_q <= '0;
         bias_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.load_valid) begin
                  din_q    <= bus.load_din;
                  weight_q <= bus.load_weight;
                  bias_q   <= bus.load_bias;
                  lfsr_a   <= SEED_A;
                  lfsr_b   <= SEED_B;
                  cnt      <= '0;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  state <= ST_IDLE;
               end else if (stream_vld) begin
                  lfsr_a <= lfsr_next(lfsr_a);
                  lfsr_b <= lfsr_next(lfsr_b);
                  cnt    <= cnt + 16'd1;
                  if (cnt == LAST) state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sc_sng_bank.sv
// Directed bench for sc_sng_bank: reset state, full runs, stalls, abort, hold-load and mid-run reset.
module tb_sc_sng_bank;
   localparam int N = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   sc_sng_bank_if #(.N(N), .W(8)) bus ();

   sc_sng_bank #(
      .K(3), .N(N), .W(8), .LEN(255), .SEED_A(8'hA5), .SEED_B(8'h3C)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int           n_valid, ones_b, n_done, done_cyc, last_vcyc, rdy_bad, leak, abort_cyc;
   int           ones_d [N];
   int           ones_w [N];
   logic [N-1:0] first_din, second_din;
   logic         rdy_after;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_load(input logic [63:0] d, input logic [63:0] w, input logic [7:0] b, input bit hold);
      bus.load_din    = d;
      bus.load_weight = w;
      bus.load_bias   = b;
      bus.load_valid  = 1'b1;
      @(negedge clk);
      chk("load_ready_idle", 64'(bus.load_ready), 64'd1);
      @(posedge clk); #1;
      if (!hold) bus.load_valid = 1'b0;
   endtask

   // Runs from the cycle after load acceptance until one cycle past done or abort.
   task automatic run_stream(input int en_off_at, input int en_off_len, input int abort_at);
      bit fin;
      fin = 1'b0;
      n_valid = 0; ones_b = 0; n_done = 0; done_cyc = -1; last_vcyc = -1;
      rdy_bad = 0; leak = 0; abort_cyc = -1; rdy_after = 1'b0;
      first_din = '0; second_din = '0;
      for (int i = 0; i < N; i++) begin
         ones_d[i] = 0;
         ones_w[i] = 0;
      end
      for (int c = 0; c < 400; c++) begin
         bus.en = !(en_off_len > 0 && c >= en_off_at && c < en_off_at + en_off_len);
         bus.abort = (abort_at >= 0 && n_valid == abort_at && abort_cyc < 0);
         if (bus.abort) abort_cyc = c;
         @(negedge clk);
         if (bus.stream_valid) begin
            n_valid++;
            last_vcyc = c;
            if (n_valid == 1) first_din = bus.din;
            if (n_valid == 2) second_din = bus.din;
            for (int i = 0; i < N; i++) begin
               ones_d[i] += int'(bus.din[i]);
               ones_w[i] += int'(bus.weight[i]);
            end
            ones_b += int'(bus.bias);
         end else if (bus.din != '0 || bus.weight != '0 || bus.bias != 1'b0) begin
            leak++;
         end
         if (bus.done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (bus.load_ready && !(done_cyc >= 0 && c > done_cyc) && !(abort_cyc >= 0 && c > abort_cyc))
            rdy_bad++;
         if ((done_cyc >= 0 && c == done_cyc + 1) || (abort_cyc >= 0 && c == abort_cyc + 1)) begin
            rdy_after = bus.load_ready;
            fin = 1'b1;
         end
         @(posedge clk); #1;
         if (fin) break;
      end
      bus.abort = 1'b0;
      bus.en    = 1'b1;
      if (!fin) chk("run_budget_expired", 64'd0, 64'd1);
   endtask

   task automatic check_ones(input logic [63:0] d, input logic [63:0] w, input logic [7:0] b);
      logic [63:0] dv, wv;
      dv = d;
      wv = w;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("din_ones[%0d]", i), 64'(ones_d[i]), 64'(dv[i*8 +: 8]));
         chk($sformatf("weight_ones[%0d]", i), 64'(ones_w[i]), 64'(wv[i*8 +: 8]));
      end
      chk("bias_ones", 64'(ones_b), 64'(b));
      chk("leak_when_invalid", 64'(leak), 64'd0);
      chk("ready_during_run", 64'(rdy_bad), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pat80, pat_d, pat_w;
      int          k;
      pat80 = {8{8'h80}};
      pat_d = 64'h55C310FFFE7F0100;
      pat_w = 64'h0102030405060708;
      bus.load_valid = 1'b0; bus.load_din = '0; bus.load_weight = '0; bus.load_bias = '0;
      bus.en = 1'b0; bus.abort = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stream_valid", 64'(bus.stream_valid), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_outputs", 64'({bus.din, bus.weight, bus.bias}), 64'd0);
      chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_load_ready", 64'(bus.load_ready), 64'd1);
      chk("post_rst_lfsr_a", 64'(dut.lfsr_a), 64'hA5);
      chk("post_rst_lfsr_b", 64'(dut.lfsr_b), 64'h3C);
      bus.en = 1'b1;

      // Full run, din=0x80, weight=0, bias=0xFF
      do_load(pat80, 64'd0, 8'hFF, 1'b0);
      run_stream(-1, 0, -1);
      chk("full_valid_cycles", 64'(n_valid), 64'd255);
      chk("full_last_valid_cyc", 64'(last_vcyc), 64'd254);
      chk("full_done_cyc", 64'(done_cyc), 64'd255);
      chk("full_done_pulses", 64'(n_done), 64'd1);
      chk("full_first_din", 64'(first_din), 64'h5A);
      chk("full_second_din", 64'(second_din), 64'hAD);
      chk("full_ready_after", 64'(rdy_after), 64'd1);
      check_ones(pat80, 64'd0, 8'hFF);

      // en low for 10 cycles mid-run stretches the run to 265 cycles
      do_load(pat80, 64'd0, 8'hFF, 1'b0);
      run_stream(100, 10, -1);
      chk("stall_valid_cycles", 64'(n_valid), 64'd255);
      chk("stall_last_valid_cyc", 64'(last_vcyc), 64'd264);
      chk("stall_done_cyc", 64'(done_cyc), 64'd265);
      chk("stall_first_din", 64'(first_din), 64'h5A);
      check_ones(pat80, 64'd0, 8'hFF);

      // Abort after 50 enabled cycles
      do_load(pat80, 64'd0, 8'hFF, 1'b0);
      run_stream(-1, 0, 50);
      chk("abort_valid_cycles", 64'(n_valid), 64'd50);
      chk("abort_done_pulses", 64'(n_done), 64'd0);
      chk("abort_ready_after", 64'(rdy_after), 64'd1);
      chk("abort_leak", 64'(leak), 64'd0);

      // load_valid held high through a run with varied lane values
      do_load(pat_d, pat_w, 8'h00, 1'b1);
      run_stream(-1, 0, -1);
      chk("hold_valid_cycles", 64'(n_valid), 64'd255);
      chk("hold_done_cyc", 64'(done_cyc), 64'd255);
      chk("hold_ready_after_done", 64'(rdy_after), 64'd1);
      check_ones(pat_d, pat_w, 8'h00);
      @(negedge clk);
      chk("hold_reload_stream_valid", 64'(bus.stream_valid), 64'd1);
      chk("hold_reload_ready", 64'(bus.load_ready), 64'd0);
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("hold_abort_ready", 64'(bus.load_ready), 64'd1);
      @(posedge clk); #1;

      // Reset mid-run after 100 stream cycles
      do_load(pat80, 64'd0, 8'hFF, 1'b0);
      k = 0;
      for (int c = 0; c < 300 && k < 100; c++) begin
         @(negedge clk);
         if (bus.stream_valid) k++;
         @(posedge clk); #1;
      end
      chk("pre_reset_cycles", 64'(k), 64'd100);
      reset = 1'b0;
      #1;
      chk("midrst_stream_valid", 64'(bus.stream_valid), 64'd0);
      chk("midrst_outputs", 64'({bus.din, bus.weight, bus.bias}), 64'd0);
      chk("midrst_load_ready", 64'(bus.load_ready), 64'd1);
      chk("midrst_lfsr_a", 64'(dut.lfsr_a), 64'hA5);
      @(negedge clk);
      chk("midrst_done", 64'(bus.done), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_midrst_done", 64'(bus.done), 64'd0);
      do_load(pat80, 64'd0, 8'hFF, 1'b0);
      run_stream(-1, 0, -1);
      chk("rerun_first_din", 64'(first_din), 64'h5A);
      chk("rerun_second_din", 64'(second_din), 64'hAD);
      chk("rerun_done_cyc", 64'(done_cyc), 64'd255);
      check_ones(pat80, 64'd0, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
